training_sequencer: RTL and testbench
=====================================

TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 3: cycles net_out is allowed to settle after a sample is applied.
REQ-002 SHALL have parameter MAX_EPOCHS, default 1000: epoch limit before forced stop.
REQ-003 SHALL have parameter DW, default 16: data width, signed Q4.12 (1.0 = 16'h1000).
REQ-004 SHALL have port clk, in, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, in, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, in, 1: level sampled in IDLE/DONE; begins training.
REQ-007 SHALL have port tol, in, DW: convergence threshold on epoch error, unsigned magnitude.
REQ-008 SHALL have port net_out, in, DW: output of final network neuron, Q4.12.
REQ-009 SHALL have ports sample_x0 and sample_x1, out, DW each: network inputs, Q4.12.
REQ-010 SHALL have port expected, out, DW: target for the current sample, Q4.12.
REQ-011 SHALL have port err, out, DW: expected minus net_out, latched in LEARN.
REQ-012 SHALL have port learn_en, out, 1: one-cycle weight-update strobe to the neurons.
REQ-013 SHALL have port epoch_done, out, 1: one-cycle pulse at end of each epoch.
REQ-014 SHALL have port epoch_err, out, 32: sum of |err| over the finished epoch.
REQ-015 SHALL have port epoch_cnt, out, 16: count of completed epochs.
REQ-016 SHALL have ports converged and busy, out, 1 each: status flags.

Function
REQ-017 SHALL implement FSM states IDLE, PRESENT, SETTLE, LEARN, NEXT, EPOCH_END, DONE.
REQ-018 IDLE/DONE -> PRESENT when start=1, clearing epoch_cnt, the accumulator, converged and sample index.
REQ-019 PRESENT (1 cycle) SHALL drive sample k: x0 = k[0]?1.0:0, x1 = k[1]?1.0:0, expected = (k[0]^k[1])?1.0:0; outputs hold until the next PRESENT.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles (SETTLE_CYCLES=0 means 1 cycle).
REQ-021 LEARN (1 cycle) SHALL assert learn_en, register err = sat16(expected - net_out), and add |err| (saturated at 16'h7FFF) to a 32-bit accumulator.
REQ-022 NEXT SHALL increment the sample index mod 4; on wrap 3->0 go to EPOCH_END, else to PRESENT.
REQ-023 EPOCH_END (1 cycle) SHALL pulse epoch_done, load epoch_err from the accumulator, clear the accumulator, and increment epoch_cnt (saturating at 16'hFFFF).
REQ-024 From EPOCH_END: if epoch_err (new value) <= tol, set converged and go to DONE; else if epoch_cnt (new value) == MAX_EPOCHS, go to DONE with converged=0; else go to PRESENT.
REQ-025 busy SHALL be 1 in every state except IDLE and DONE.
REQ-026 start while busy SHALL be ignored.
REQ-027 Latency per sample SHALL be SETTLE_CYCLES+3 cycles; per epoch 4*(SETTLE_CYCLES+3)+1 cycles.

Reset
REQ-028 rst_n low SHALL immediately force IDLE; all outputs 0, epoch_cnt 0, accumulator 0, index 0, even mid-epoch.
REQ-029 After rst_n rises, no learn_en or epoch_done SHALL occur until start is sampled high.

Configuration
REQ-030 With TRAIN_SHUFFLE_EN defined, the presented sample SHALL be k = index XOR perm, where perm is the 2-bit value latched from an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5, stepping every cycle) at each epoch start.
REQ-031 Without TRAIN_SHUFFLE_EN, perm SHALL be 0, the LFSR SHALL NOT exist, and samples SHALL be presented in order 0,1,2,3.

Structure
REQ-032 A shared package SHALL hold the Q4.12 constants (ONE, ZERO), the FSM state enum, and the sat16/abs16 functions.
REQ-033 The sat16/abs16 error computation MAY be a sub-module named error_accum; everything else SHALL be flat.

Verification
REQ-034 Reset mid-SETTLE -> IDLE next cycle, busy=0, all outputs 0.
REQ-035 start=1, net_out tied to 16'h0000, SETTLE_CYCLES=3 -> epoch_done first occurs 25 cycles after start; epoch_err=32'h2000 (two samples miss by 1.0); converged=0.
REQ-036 net_out driven by an ideal XOR model, tol=0 -> converged=1 after epoch 1, epoch_cnt=1, DONE.
REQ-037 net_out = 16'h8000, expected 1.0 -> err saturates to 16'h7FFF, accumulator adds 16'h7FFF.
REQ-038 MAX_EPOCHS=2, net_out=0, tol=0 -> DONE after 2 epochs, epoch_cnt=2, converged=0.
REQ-039 TRAIN_SHUFFLE_EN defined -> each epoch presents all four samples exactly once, with order matching the LFSR reference model.

Source files
------------

// File: rtl/training_sequencer_pkg.sv
// Shared types, Q4.12 constants and saturation helpers for the training sequencer.
package training_sequencer_pkg;

  localparam logic [15:0] ONE  = 16'h1000;
  localparam logic [15:0] ZERO = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StPresent,
    StSettle,
    StLearn,
    StNext,
    StEpochEnd,
    StDone
  } state_e;

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] expected;
  } sample_t;

  function automatic logic [15:0] sat16(input logic signed [16:0] v);
    logic [15:0] r;
    if (v > 17'sd32767) begin
      r = 16'h7FFF;
    end else if (v < -17'sd32768) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  // Magnitude of a Q4.12 value; -8.0 has no positive twin so it clips to 16'h7FFF.
  function automatic logic [15:0] abs16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'h8000) begin
      r = 16'h7FFF;
    end else if (v[15]) begin
      r = ~v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic sample_t make_sample(input logic [1:0] k);
    sample_t s;
    s.x0       = k[0] ? ONE : ZERO;
    s.x1       = k[1] ? ONE : ZERO;
    s.expected = (k[0] ^ k[1]) ? ONE : ZERO;
    return s;
  endfunction

endpackage

// File: rtl/error_accum.sv
// Saturated error (expected - net_out) and running |err| accumulation for one sample.
module error_accum
  import training_sequencer_pkg::*;
(
  input  logic [15:0] expected,
  input  logic [15:0] net_out,
  input  logic [31:0] acc,
  output logic [15:0] err,
  output logic [31:0] acc_next
);

  logic signed [16:0] diff;

  always_comb begin
    diff     = $signed({expected[15], expected}) - $signed({net_out[15], net_out});
    err      = sat16(diff);
    acc_next = acc + {16'h0000, abs16(err)};
  end

endmodule

// File: rtl/training_sequencer.sv
// XOR training-set sequencer: presents samples, strobes weight updates, tracks epoch error.
// Optional macro TRAIN_SHUFFLE_EN permutes sample order per epoch from an 8-bit LFSR.
module training_sequencer
  import training_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned MAX_EPOCHS    = 1000,
  parameter int unsigned DW            = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] tol,
  input  logic [DW-1:0] net_out,
  output logic [DW-1:0] sample_x0,
  output logic [DW-1:0] sample_x1,
  output logic [DW-1:0] expected,
  output logic [DW-1:0] err,
  output logic          learn_en,
  output logic          epoch_done,
  output logic [31:0]   epoch_err,
  output logic [15:0]   epoch_cnt,
  output logic          converged,
  output logic          busy
);

  localparam int unsigned SettleLen  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [15:0] SettleLast = 16'(SettleLen - 1);
  localparam logic [15:0] EpochLimit = 16'(MAX_EPOCHS);

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [1:0]    perm_q;
  logic [15:0]   settle_cnt_q;
  logic [31:0]   acc_q;
  logic [1:0]    epoch_perm;
  logic [DW-1:0] err_d;
  logic [31:0]   acc_d;

`ifdef TRAIN_SHUFFLE_EN
  logic [7:0] lfsr_q;

  // Fibonacci form of x^8+x^6+x^5+x^4+1, free-running from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign epoch_perm = lfsr_q[1:0];
`else
  assign epoch_perm = 2'b00;
`endif

  error_accum u_error_accum (
    .expected (expected),
    .net_out  (net_out),
    .acc      (acc_q),
    .err      (err_d),
    .acc_next (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= 2'b00;
      perm_q       <= 2'b00;
      settle_cnt_q <= 16'h0000;
      acc_q        <= 32'h0;
      sample_x0    <= '0;
      sample_x1    <= '0;
      expected     <= '0;
      err          <= '0;
      learn_en     <= 1'b0;
      epoch_done   <= 1'b0;
      epoch_err    <= 32'h0;
      epoch_cnt    <= 16'h0000;
      converged    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      learn_en   <= 1'b0;
      epoch_done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StPresent;
            busy      <= 1'b1;
            epoch_cnt <= 16'h0000;
            acc_q     <= 32'h0;
            converged <= 1'b0;
            idx_q     <= 2'b00;
            perm_q    <= epoch_perm;
            {sample_x0, sample_x1, expected} <= make_sample(epoch_perm);
          end
        end
        StPresent: begin
          state_q      <= StSettle;
          settle_cnt_q <= 16'h0000;
        end
        StSettle: begin
          if (settle_cnt_q == SettleLast) begin
            state_q  <= StLearn;
            learn_en <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + 16'd1;
          end
        end
        StLearn: begin
          err     <= err_d;
          acc_q   <= acc_d;
          state_q <= StNext;
        end
        StNext: begin
          if (idx_q == 2'd3) begin
            idx_q      <= 2'b00;
            state_q    <= StEpochEnd;
            epoch_done <= 1'b1;
            epoch_err  <= acc_q;
            acc_q      <= 32'h0;
            if (epoch_cnt != 16'hFFFF) begin
              epoch_cnt <= epoch_cnt + 16'd1;
            end
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= StPresent;
            {sample_x0, sample_x1, expected} <= make_sample((idx_q + 2'd1) ^ perm_q);
          end
        end
        StEpochEnd: begin
          // Decision uses the epoch_err/epoch_cnt values loaded on entry.
          if (epoch_err <= {{(32 - DW){1'b0}}, tol}) begin
            converged <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StDone;
          end else if (epoch_cnt == EpochLimit) begin
            busy    <= 1'b0;
            state_q <= StDone;
          end else begin
            state_q <= StPresent;
            perm_q  <= epoch_perm;
            {sample_x0, sample_x1, expected} <= make_sample(epoch_perm);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Self-checking bench for training_sequencer: vector table, corner sequences, random runs.
module tb_training_sequencer;

  localparam int unsigned Settle = 3;
  localparam int unsigned MaxEp  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tol = 16'h0;
  logic [15:0] net_out;
  logic [15:0] sample_x0, sample_x1, expected, err;
  logic        learn_en, epoch_done, converged, busy;
  logic [31:0] epoch_err;
  logic [15:0] epoch_cnt;

  logic [1:0]  net_mode = 2'd0;
  logic [15:0] net_const = 16'h0;
  logic [15:0] net_rnd = 16'h0;

  int checks = 0;
  int errors = 0;

  training_sequencer #(
    .SETTLE_CYCLES (Settle),
    .MAX_EPOCHS    (MaxEp),
    .DW            (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .tol        (tol),
    .net_out    (net_out),
    .sample_x0  (sample_x0),
    .sample_x1  (sample_x1),
    .expected   (expected),
    .err        (err),
    .learn_en   (learn_en),
    .epoch_done (epoch_done),
    .epoch_err  (epoch_err),
    .epoch_cnt  (epoch_cnt),
    .converged  (converged),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Network stand-in: constant, ideal XOR of the presented inputs, or random.
  assign net_out = (net_mode == 2'd0) ? net_const :
                   (net_mode == 2'd1) ? (((sample_x0 != 0) ^ (sample_x1 != 0)) ? 16'h1000 : 16'h0)
                                      : net_rnd;

  always @(negedge clk) net_rnd = 16'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int ref_sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int ref_abs(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > 32767) ? 32767 : a;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'b1011_1000)};
  endfunction

  function automatic logic [1:0] perm_of(input logic [7:0] l);
`ifdef TRAIN_SHUFFLE_EN
    return l[1:0];
`else
    return 2'b00 & l[1:0];
`endif
  endfunction

  // Reference model, advanced on observed strobes.
  bit          running;
  int          cyc, m_idx, m_ep, ep_start, last_learn;
  longint      m_acc;
  bit          m_conv;
  logic [1:0]  m_perm;
  logic [7:0]  m_lfsr;
  bit          err_pend;
  logic [15:0] err_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running = 0; cyc = 0; m_idx = 0; m_ep = 0; m_acc = 0; m_conv = 0;
      m_perm = 2'b00; m_lfsr = 8'hA5; err_pend = 0;
    end else begin
      cyc++;
      if (err_pend) begin
        chk("err register", {16'h0, err}, {16'h0, err_exp});
        err_pend = 0;
      end
      if (learn_en) begin
        chk("learn_en only while training", {31'h0, learn_en}, {31'h0, running});
        if (running) begin
          logic [1:0]  k;
          logic [15:0] xv;
          int          e;
          k  = 2'(m_idx) ^ m_perm;
          xv = (k[0] ^ k[1]) ? 16'h1000 : 16'h0;
          chk("sample_x0", {16'h0, sample_x0}, k[0] ? 32'h1000 : 32'h0);
          chk("sample_x1", {16'h0, sample_x1}, k[1] ? 32'h1000 : 32'h0);
          chk("expected", {16'h0, expected}, {16'h0, xv});
          e = ref_sat(int'($signed(xv)) - int'($signed(net_out)));
          err_exp = 16'(e);
          err_pend = 1;
          m_acc += ref_abs(e);
          if (m_idx == 0) chk("first learn latency", 32'(cyc - ep_start), 32'(Settle + 2));
          else chk("sample spacing", 32'(cyc - last_learn), 32'(Settle + 3));
          last_learn = cyc;
          m_idx++;
        end
      end
      if (epoch_done) begin
        chk("epoch_err", epoch_err, 32'(m_acc));
        chk("epoch_cnt at epoch end", {16'h0, epoch_cnt}, 32'((m_ep < 65535) ? m_ep + 1 : m_ep));
        chk("samples per epoch", 32'(m_idx), 32'd4);
        chk("epoch latency", 32'(cyc - ep_start), 32'(4 * (Settle + 3) + 1));
        if (m_ep < 65535) m_ep++;
        if (m_acc <= longint'(tol)) begin
          m_conv = 1; running = 0;
        end else if (m_ep == MaxEp) begin
          running = 0;
        end else begin
          m_perm = perm_of(m_lfsr); m_idx = 0; ep_start = cyc;
        end
        m_acc = 0;
      end
      if (start && !busy) begin
        running = 1; m_ep = 0; m_acc = 0; m_conv = 0; m_idx = 0;
        m_perm = perm_of(m_lfsr); ep_start = cyc;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  task automatic run_once(input bit poke);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (poke) begin
      repeat (8) @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk("run completes (busy low)", {31'h0, busy}, 32'h0);
    chk("converged vs model", {31'h0, converged}, {31'h0, m_conv});
    chk("epoch_cnt vs model", {16'h0, epoch_cnt}, 32'(m_ep));
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] netc;
    logic [15:0] tolv;
    logic [15:0] ep;
    logic        conv;
    logic [31:0] eerr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, pulses;
    vecs[0] = '{2'd0, 16'h0000, 16'h0000, 16'd2, 1'b0, 32'h2000};
    vecs[1] = '{2'd1, 16'h0000, 16'h0000, 16'd1, 1'b1, 32'h0};
    vecs[2] = '{2'd0, 16'h0000, 16'h2000, 16'd1, 1'b1, 32'h2000};
    vecs[3] = '{2'd0, 16'h0000, 16'h1FFF, 16'd2, 1'b0, 32'h2000};
    vecs[4] = '{2'd0, 16'h8000, 16'h0000, 16'd2, 1'b0, 32'h1FFFC};
    vecs[5] = '{2'd0, 16'h1000, 16'h2000, 16'd1, 1'b1, 32'h2000};
    vecs[6] = '{2'd0, 16'h7FFF, 16'hFFFF, 16'd2, 1'b0, 32'h1DFFC};

    repeat (3) @(negedge clk);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset epoch_cnt", {16'h0, epoch_cnt}, 32'h0);
    chk("reset outputs", {sample_x0, sample_x1}, 32'h0);
    chk("reset err/expected", {err, expected}, 32'h0);
    chk("reset flags", {28'h0, learn_en, epoch_done, converged, busy}, 32'h0);
    rst_n = 1'b1;

    // First epoch against a dead network: epoch_done 25 cycles after start.
    net_mode = 2'd0; net_const = 16'h0; tol = 16'h0;
    @(negedge clk); start = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (epoch_done) break;
    end
    chk("epoch_done latency from start", 32'(n), 32'd25);
    chk("first epoch_err", epoch_err, 32'h2000);
    chk("not converged after epoch 1", {31'h0, converged}, 32'h0);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("max epochs reached", {16'h0, epoch_cnt}, 32'd2);
    chk("max epochs not converged", {31'h0, converged}, 32'h0);

    // Reset in the middle of SETTLE.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async reset busy", {31'h0, busy}, 32'h0);
    chk("async reset samples", {sample_x0, sample_x1}, 32'h0);
    chk("async reset counters", {epoch_cnt, expected}, 32'h0);
    @(negedge clk);
    chk("reset held err/epoch_err", {16'h0, err} | epoch_err, 32'h0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses += int'(learn_en) + int'(epoch_done) + int'(busy);
    end
    chk("quiet after reset without start", 32'(pulses), 32'h0);

    // Table-driven runs.
    foreach (vecs[v]) begin
      @(negedge clk);
      net_mode = vecs[v].mode; net_const = vecs[v].netc; tol = vecs[v].tolv;
      run_once(1'b0);
      chk($sformatf("vec%0d epoch_cnt", v), {16'h0, epoch_cnt}, {16'h0, vecs[v].ep});
      chk($sformatf("vec%0d converged", v), {31'h0, converged}, {31'h0, vecs[v].conv});
      chk($sformatf("vec%0d epoch_err", v), epoch_err, vecs[v].eerr);
    end

    // Randomised runs, one with start pulsed while busy.
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      net_mode = (r % 3 == 0) ? 2'd1 : 2'd2;
      tol = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h3000));
      run_once(r == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
